attention_engine_p: RTL and testbench

Parametrised successor to the fixed 8x8 attention datapath. Loads N x N unsigned matrices Q, K and V, computes S = Q x K^T and then O = S x V using LANES parallel multipliers. Streams O out with a valid/ready handshake. Returns to loading after each matrix set, so it can process back-to-back sets; it sits between the operand loader and the result sink.

---
 rtl/attn_pkg.sv | 27 ++
 rtl/attn_dot_lanes.sv | 60 ++++++
 rtl/attention_engine_p.sv | 233 +++++++++++++++++++++++
 tb/tb_attention_engine_p.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/attn_pkg.sv
// attn_pkg: shared types and width helpers for the attention engine.
package attn_pkg;

    // Top-level sequencing: load operands, compute S, compute O, stream O.
    typedef enum logic [1:0] {
        StLoad,
        StCalcS,
        StCalcO,
        StOut
    } state_e;

    // Width of one S element: DW*DW products summed over N terms.
    function automatic int unsigned s_width(input int unsigned dw, input int unsigned n);
        return 2 * dw + $clog2(n);
    endfunction

    // Width of one O element: SW*DW products summed over N terms.
    function automatic int unsigned o_width(input int unsigned dw, input int unsigned n);
        return s_width(dw, n) + dw + $clog2(n);
    endfunction

    // Operand beats needed per output element.
    function automatic int unsigned beat_count(input int unsigned n, input int unsigned lanes);
        return n / lanes;
    endfunction

endpackage

// File: rtl/attn_dot_lanes.sv
// attn_dot_lanes: LANES multipliers feeding an adder tree, then an accumulator that restarts
// on the first beat of each element. Result appears 2 cycles after the last beat.
module attn_dot_lanes #(
    parameter int unsigned LANES = 8,
    parameter int unsigned AW    = 11,
    parameter int unsigned BW    = 4,
    parameter int unsigned RW    = 18
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic                      in_last,
    input  logic [LANES-1:0][AW-1:0]  op_a,
    input  logic [LANES-1:0][BW-1:0]  op_b,
    output logic                      out_valid,
    output logic [RW-1:0]             result
);

    logic [RW-1:0] tree_sum;
    logic [RW-1:0] s1_sum_q;
    logic          s1_valid_q;
    logic          s1_first_q;
    logic          s1_last_q;
    logic [RW-1:0] acc_q;
    logic          out_valid_q;

    // Lane products summed; RW is wide enough that no term or sum overflows.
    always_comb begin
        tree_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            tree_sum = tree_sum + RW'(op_a[l]) * RW'(op_b[l]);
        end
    end

    // Stage 1 registers the tree sum; stage 2 accumulates across beats.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_sum_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_sum_q   <= tree_sum;
            s1_valid_q <= in_valid;
            s1_first_q <= in_first;
            s1_last_q  <= in_last;
            if (s1_valid_q) begin
                acc_q <= s1_first_q ? s1_sum_q : acc_q + s1_sum_q;
            end
            out_valid_q <= s1_valid_q & s1_last_q;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = acc_q;

endmodule

// File: rtl/attention_engine_p.sv
// attention_engine_p: loads N x N matrices Q, K, V, computes S = Q x K^T then O = S x V on one
// shared LANES-wide dot-product unit, and streams O out row-major over valid/ready.
// Build option: define ATTN_SCALE_EN to store each S element as (sum >> SCALE_SHIFT).
module attention_engine_p
    import attn_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned DW          = 4,
    parameter int unsigned LANES       = 8,
    parameter int unsigned SCALE_SHIFT = 3,
    localparam int unsigned OW         = o_width(DW, N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          in_ready,
    input  logic [DW-1:0] MATRIX_Q,
    input  logic [DW-1:0] MATRIX_K,
    input  logic [DW-1:0] MATRIX_V,
    output logic [OW-1:0] answer,
    output logic          answer_valid,
    input  logic          answer_ready,
    output logic          done,
    output logic          busy
);

    localparam int unsigned LG    = $clog2(N);
    localparam int unsigned SW    = s_width(DW, N);
    localparam int unsigned NN    = N * N;
    localparam int unsigned IW    = 2 * LG;
    localparam int unsigned BEATS = beat_count(N, LANES);
    localparam int unsigned BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned ISSUE = NN * BEATS;
    localparam int unsigned PHASE = ISSUE + 2;  // issue beats plus unit latency
    localparam int unsigned CW    = $clog2(PHASE);

    logic [DW-1:0] q_mem [NN];
    logic [DW-1:0] k_mem [NN];
    logic [DW-1:0] v_mem [NN];
    logic [SW-1:0] s_mem [NN];
    logic [OW-1:0] o_mem [NN];

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  oidx_q, oidx_d;
    logic [IW-1:0]  wr_q, wr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LG-1:0]  row_q, row_d;
    logic [LG-1:0]  col_q, col_d;
    logic [BCW-1:0] beat_q, beat_d;
    logic [OW-1:0]  answer_q, answer_d;
    logic           answer_valid_q, answer_valid_d;
    logic           done_q, done_d;

    logic                     load_we;
    logic                     issue;
    logic                     dot_valid;
    logic [OW-1:0]            dot_result;
    logic [SW-1:0]            s_wdata;
    logic [LANES-1:0][SW-1:0] op_a;
    logic [LANES-1:0][DW-1:0] op_b;

`ifdef ATTN_SCALE_EN
    assign s_wdata = SW'(dot_result >> SCALE_SHIFT);
`else
    logic unused_scale_shift;
    assign unused_scale_shift = ^SCALE_SHIFT;
    assign s_wdata = SW'(dot_result);
`endif

    // Sequencing, issue counters and output handshake.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        oidx_d         = oidx_q;
        wr_d           = wr_q;
        cnt_d          = cnt_q;
        row_d          = row_q;
        col_d          = col_q;
        beat_d         = beat_q;
        answer_d       = answer_q;
        answer_valid_d = answer_valid_q;
        done_d         = 1'b0;
        load_we        = 1'b0;
        issue          = 1'b0;

        unique case (state_q)
            StLoad: begin
                if (en) begin
                    load_we = 1'b1;
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IW'(NN - 1)) begin
                        idx_d   = '0;
                        state_d = StCalcS;
                    end
                end
            end
            StCalcS, StCalcO: begin
                issue = (cnt_q < CW'(ISSUE));
                if (issue) begin
                    // Row-major element order, beats innermost.
                    if (beat_q == BCW'(BEATS - 1)) begin
                        beat_d = '0;
                        if (col_q == LG'(N - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                if (dot_valid) begin
                    wr_d = wr_q + 1'b1;
                end
                if (cnt_q == CW'(PHASE - 1)) begin
                    cnt_d = '0;
                    if (state_q == StCalcS) begin
                        state_d = StCalcO;
                    end else begin
                        state_d        = StOut;
                        oidx_d         = '0;
                        answer_valid_d = 1'b1;
                        // O[0] was written long before the final O write on this edge.
                        answer_d       = o_mem[0];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StOut: begin
                if (answer_ready) begin
                    if (oidx_q == IW'(NN - 1)) begin
                        oidx_d         = '0;
                        answer_valid_d = 1'b0;
                        done_d         = 1'b1;
                        state_d        = StLoad;
                    end else begin
                        oidx_d   = oidx_q + 1'b1;
                        answer_d = o_mem[oidx_q + 1'b1];
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    // Operand selection: Q/K rows in S mode, S row and V column in O mode.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int l = 0; l < LANES; l++) begin
            logic [LG-1:0] kidx;
            kidx = LG'(int'(beat_q) * int'(LANES) + l);
            if (state_q == StCalcO) begin
                op_a[l] = s_mem[{row_q, kidx}];
                op_b[l] = v_mem[{kidx, col_q}];
            end else begin
                op_a[l] = SW'(q_mem[{row_q, kidx}]);
                op_b[l] = k_mem[{col_q, kidx}];
            end
        end
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= StLoad;
            idx_q          <= '0;
            oidx_q         <= '0;
            wr_q           <= '0;
            cnt_q          <= '0;
            row_q          <= '0;
            col_q          <= '0;
            beat_q         <= '0;
            answer_q       <= '0;
            answer_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            oidx_q         <= oidx_d;
            wr_q           <= wr_d;
            cnt_q          <= cnt_d;
            row_q          <= row_d;
            col_q          <= col_d;
            beat_q         <= beat_d;
            answer_q       <= answer_d;
            answer_valid_q <= answer_valid_d;
            done_q         <= done_d;
        end
    end

    // Matrix storage; never cleared since every set overwrites it completely.
    always_ff @(posedge clk) begin
        if (load_we) begin
            q_mem[idx_q] <= MATRIX_Q;
            k_mem[idx_q] <= MATRIX_K;
            v_mem[idx_q] <= MATRIX_V;
        end
        if (dot_valid && state_q == StCalcS) begin
            s_mem[wr_q] <= s_wdata;
        end
        if (dot_valid && state_q == StCalcO) begin
            o_mem[wr_q] <= dot_result;
        end
    end

    attn_dot_lanes #(
        .LANES (LANES),
        .AW    (SW),
        .BW    (DW),
        .RW    (OW)
    ) u_dot (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue),
        .in_first  (beat_q == '0),
        .in_last   (beat_q == BCW'(BEATS - 1)),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (dot_valid),
        .result    (dot_result)
    );

    assign in_ready     = (state_q == StLoad);
    assign busy         = (state_q != StLoad);
    assign answer       = answer_q;
    assign answer_valid = answer_valid_q;
    assign done         = done_q;

endmodule

// File: tb/tb_attention_engine_p.sv
// tb_attention_engine_p: directed sequence with random data and random sink back-pressure,
// checked against a plain matrix-arithmetic model. Two engines: LANES=8 (index 0), LANES=2 (1).
`timescale 1ns/1ps
module tb_attention_engine_p;

    localparam int unsigned N     = 8;
    localparam int unsigned DW    = 4;
    localparam int unsigned LG    = 3;
    localparam int unsigned NN    = N * N;
    localparam int unsigned OW    = 2 * DW + LG + DW + LG;
    localparam int unsigned SHIFT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] mq_in, mk_in, mv_in;
    logic          en [2];
    logic          ans_ready [2];
    logic          in_ready [2];
    logic          answer_valid [2];
    logic          done [2];
    logic          busy [2];
    logic [OW-1:0] answer [2];

    int unsigned q [NN];
    int unsigned k [NN];
    int unsigned v [NN];
    longint      exp_o [NN];

    int checks = 0;
    int errors = 0;
    int gap;

    always #5 clk = ~clk;

    attention_engine_p #(.N(N), .DW(DW), .LANES(8), .SCALE_SHIFT(SHIFT)) dut_l8 (
        .clk(clk), .reset(reset), .en(en[0]), .in_ready(in_ready[0]),
        .MATRIX_Q(mq_in), .MATRIX_K(mk_in), .MATRIX_V(mv_in),
        .answer(answer[0]), .answer_valid(answer_valid[0]), .answer_ready(ans_ready[0]),
        .done(done[0]), .busy(busy[0])
    );

    attention_engine_p #(.N(N), .DW(DW), .LANES(2), .SCALE_SHIFT(SHIFT)) dut_l2 (
        .clk(clk), .reset(reset), .en(en[1]), .in_ready(in_ready[1]),
        .MATRIX_Q(mq_in), .MATRIX_K(mk_in), .MATRIX_V(mv_in),
        .answer(answer[1]), .answer_valid(answer_valid[1]), .answer_ready(ans_ready[1]),
        .done(done[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // O = (Q x K^T [>> SHIFT]) x V with plain integer arithmetic.
    task automatic build_model();
        longint s [NN];
        longint acc;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                acc = 0;
                for (int i = 0; i < N; i++) acc += longint'(q[r*N+i]) * longint'(k[c*N+i]);
`ifdef ATTN_SCALE_EN
                acc = acc >> SHIFT;
`endif
                s[r*N+c] = acc;
            end
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                acc = 0;
                for (int i = 0; i < N; i++) acc += s[r*N+i] * longint'(v[i*N+c]);
                exp_o[r*N+c] = acc;
            end
        end
    endtask

    task automatic set_fill(input int unsigned val);
        for (int i = 0; i < NN; i++) begin
            q[i] = val; k[i] = val; v[i] = val;
        end
        build_model();
    endtask

    task automatic set_identity();
        for (int i = 0; i < NN; i++) begin
            q[i] = (i / N == i % N) ? 1 : 0;
            k[i] = q[i];
            v[i] = i % 16;
        end
        build_model();
    endtask

    task automatic set_random();
        for (int i = 0; i < NN; i++) begin
            q[i] = $urandom_range(0, 15);
            k[i] = $urandom_range(0, 15);
            v[i] = $urandom_range(0, 15);
        end
        build_model();
    endtask

    task automatic load_set(input int sel);
        chk("in_ready_before_load", in_ready[sel], 1);
        for (int i = 0; i < NN; i++) begin
            mq_in = DW'(q[i]); mk_in = DW'(k[i]); mv_in = DW'(v[i]);
            en[sel] = 1'b1;
            @(posedge clk); #1;
        end
        en[sel] = 1'b0;
        chk("busy_after_load", busy[sel], 1);
    endtask

    // mode 0: always ready; 1: random ready; 2: random ready plus 10-cycle stall at element 5.
    task automatic drain(input int sel, input int mode, output int first_gap);
        int   got = 0;
        int   cyc = 0;
        int   hold = 0;
        int   g = -1;
        logic held = 1'b0;
        logic rdy;
        logic [OW-1:0] prev = '0;
        while (got < NN && cyc < 4000) begin
            rdy = 1'b1;
            if (mode >= 1) rdy = 1'($urandom_range(0, 1));
            if (mode == 2 && got == 5 && hold < 10) begin
                rdy = 1'b0;
                hold++;
            end
            ans_ready[sel] = rdy;
            if (held) begin
                chk("stall_valid_held", answer_valid[sel], 1);
                chk("stall_answer_stable", answer[sel], prev);
            end
            chk("done_early", done[sel], 0);
            if (answer_valid[sel]) begin
                if (g < 0) g = cyc;
                if (rdy) begin
                    chk($sformatf("answer[%0d]", got), answer[sel], exp_o[got]);
                    got++;
                end
                held = !rdy;
                prev = answer[sel];
            end else begin
                held = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (got < NN) chk("drain_timeout", got, NN);
        chk("done_pulse", done[sel], 1);
        chk("valid_after_last", answer_valid[sel], 0);
        chk("busy_after_last", busy[sel], 0);
        chk("in_ready_after_last", in_ready[sel], 1);
        ans_ready[sel] = 1'b1;
        @(posedge clk); #1;
        chk("done_one_cycle", done[sel], 0);
        chk("answer_kept", answer[sel], exp_o[NN-1]);
        first_gap = g;
    endtask

    initial begin
        reset = 1'b0;
        en[0] = 1'b0; en[1] = 1'b0;
        ans_ready[0] = 1'b1; ans_ready[1] = 1'b1;
        mq_in = '0; mk_in = '0; mv_in = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("rst_in_ready", in_ready[s], 1);
            chk("rst_answer_valid", answer_valid[s], 0);
            chk("rst_answer", answer[s], 0);
            chk("rst_done", done[s], 0);
            chk("rst_busy", busy[s], 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;

        // All ones.
        set_fill(1);
        load_set(0);
        drain(0, 0, gap);

        // All fifteen, with exact load-to-output latency.
        set_fill(15);
        load_set(0);
        drain(0, 0, gap);
        chk("gap_lanes8", gap, 2 * (NN * (N / 8) + 2));

        // Identity Q and K pass V through.
        set_identity();
        load_set(0);
        drain(0, 0, gap);

        // Random data with back-pressure and a long stall.
        set_random();
        load_set(0);
        drain(0, 2, gap);

        // LANES=2: longer phases, then a second set straight after.
        set_fill(15);
        load_set(1);
        drain(1, 0, gap);
        chk("gap_lanes2", gap, 2 * (NN * (N / 2) + 2));
        set_random();
        load_set(1);
        drain(1, 1, gap);

        // Reset in the middle of CALC_S aborts the set.
        set_random();
        load_set(0);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy_before_reset", busy[0], 1);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_in_ready", in_ready[0], 1);
        chk("mid_rst_answer_valid", answer_valid[0], 0);
        chk("mid_rst_answer", answer[0], 0);
        chk("mid_rst_busy", busy[0], 0);
        reset = 1'b1;
        @(posedge clk); #1;
        set_random();
        load_set(0);
        drain(0, 1, gap);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
